// File: rtl/vga_fb_pkg.sv
// Shared constants, state encoding and pixel helper for the framebuffer reader.
package vga_fb_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 4;
  localparam int ADDR_W       = 15;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  // IDLE: no frame; FETCH: reads still to issue; DRAIN: all reads issued, pixels pending.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  // Pixel idx of a packed word; pixel 0 lives in the least significant byte.
  function automatic logic [PIX_W-1:0] pick_pixel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
    logic [PIX_W-1:0] pix;
    pix = word[0*PIX_W +: PIX_W];
    case (idx)
      2'd1:    pix = word[1*PIX_W +: PIX_W];
      2'd2:    pix = word[2*PIX_W +: PIX_W];
      2'd3:    pix = word[3*PIX_W +: PIX_W];
      default: pix = word[0*PIX_W +: PIX_W];
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// Show-ahead synchronous word FIFO with flush and occupancy count.
module fb_word_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [WORD_W-1:0]          i_wr_data,
  input  logic                       i_rd_en,
  output logic [WORD_W-1:0]          o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_wr;
  logic              w_do_rd;

  assign w_do_wr   = i_wr_en && !i_flush && (r_count != (AW+1)'(DEPTH));
  assign w_do_rd   = i_rd_en && !i_flush && (r_count != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  // Storage array: written on push only.
  // NOTE: the storage has no reset; it is never read while empty, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and count; flush empties the FIFO in one cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_reader.sv
// Avalon-MM framebuffer read master: credit-limited pipelined word reads,
// word FIFO, and a 4-pixel-per-word unpacker with valid/ready output.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 4800,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [WORD_W-1:0] avm_writedata,
  input  logic [WORD_W-1:0] avm_readdata,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_sop,
  output logic              pixel_eop,
  output logic              busy,
  output logic              frame_done
);

  localparam int                CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int                WL_W  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [WL_W-1:0]   FRAME = WL_W'(FRAME_WORDS);
  localparam logic [WL_W-1:0]   LAST  = WL_W'(FRAME_WORDS - 1);

  // Read side
  fb_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [WL_W-1:0]   r_words_left, w_words_left_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_inflight, w_inflight_nxt;
  logic              w_last_issue;
  int                w_fifo_count_nxt;

  // FIFO
  logic              w_fifo_wr, w_fifo_rd, w_fifo_empty;
  logic [WORD_W-1:0] w_fifo_rd_data;
  logic [CNT_W-1:0]  w_fifo_count;

  // Unpacker
  logic [WORD_W-1:0] r_word, w_word_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic              r_hold_valid, w_hold_valid_nxt;
  logic              r_hold_first, w_hold_first_nxt;
  logic              r_hold_last, w_hold_last_nxt;
  logic [WL_W-1:0]   r_loads, w_loads_nxt;
  logic              w_accept, w_need, w_avail, w_load, w_eop_accept;
  logic [WORD_W-1:0] w_src;

  // Registered output copies
  logic [PIX_W-1:0]  r_pixel;
  logic              r_sop, r_eop, r_busy, r_frame_done;

  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_writedata  = '0;
  assign pixel          = r_pixel;
  assign pixel_valid    = r_hold_valid;
  assign pixel_sop      = r_sop;
  assign pixel_eop      = r_eop;
  assign busy           = r_busy;
  assign frame_done     = r_frame_done;

  // A read is taken by memory at every edge where chipselect is high.
  assign w_last_issue = r_cs && (r_words_left == WL_W'(1));

  // Unpacker handshake and word sourcing: an empty holder takes the FIFO head,
  // or the returning word directly when the FIFO is empty.
  assign w_accept     = r_hold_valid && pixel_ready;
  assign w_need       = !r_hold_valid || (w_accept && (r_idx == 2'd3));
  assign w_avail      = !w_fifo_empty || r_inflight;
  assign w_load       = w_need && w_avail;
  assign w_src        = w_fifo_empty ? avm_readdata : w_fifo_rd_data;
  assign w_fifo_rd    = w_load && !w_fifo_empty;
  assign w_fifo_wr    = r_inflight && !(w_load && w_fifo_empty);
  assign w_eop_accept = w_accept && r_hold_last && (r_idx == 2'd3);

  fb_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_flush   (frame_start),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (avm_readdata),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_fifo_rd_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; frame_start restarts from any state.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (frame_start)       w_state_nxt = FETCH;
      FETCH:   if (frame_start)       w_state_nxt = FETCH;
               else if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (frame_start)       w_state_nxt = FETCH;
               else if (w_eop_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read pointer, word budget and in-flight tracking; the last issue leaves the
  // address on the final word so it never passes the frame end or wraps.
  always_comb begin
    w_addr_nxt       = r_addr;
    w_words_left_nxt = r_words_left;
    w_inflight_nxt   = 1'b0;
    if (frame_start) begin
      w_addr_nxt       = BASE;
      w_words_left_nxt = FRAME;
    end else if (r_cs) begin
      w_inflight_nxt   = 1'b1;
      w_words_left_nxt = r_words_left - 1'b1;
      if (!w_last_issue) w_addr_nxt = r_addr + 1'b1;
    end
  end

  // Credit: request another word only if FIFO plus in-flight plus it still fits.
  always_comb begin
    w_fifo_count_nxt = int'(w_fifo_count) + (w_fifo_wr ? 1 : 0) - (w_fifo_rd ? 1 : 0);
    if (frame_start) w_fifo_count_nxt = 0;
    w_cs_nxt = (w_state_nxt == FETCH) && (w_words_left_nxt != '0) &&
               (w_fifo_count_nxt + (w_inflight_nxt ? 1 : 0) + 1 <= FIFO_DEPTH);
  end

  // Read-side registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= BASE;
      r_words_left <= '0;
      r_cs         <= 1'b0;
      r_inflight   <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_words_left <= w_words_left_nxt;
      r_cs         <= w_cs_nxt;
      r_inflight   <= w_inflight_nxt;
    end
  end

  // Unpacker next state: flush on restart, reload at idx 3 or when empty, else step idx.
  always_comb begin
    w_word_nxt       = r_word;
    w_idx_nxt        = r_idx;
    w_hold_valid_nxt = r_hold_valid;
    w_hold_first_nxt = r_hold_first;
    w_hold_last_nxt  = r_hold_last;
    w_loads_nxt      = r_loads;
    if (frame_start) begin
      w_idx_nxt        = 2'd0;
      w_hold_valid_nxt = 1'b0;
      w_hold_first_nxt = 1'b0;
      w_hold_last_nxt  = 1'b0;
      w_loads_nxt      = '0;
    end else if (w_load) begin
      w_word_nxt       = w_src;
      w_idx_nxt        = 2'd0;
      w_hold_valid_nxt = 1'b1;
      w_hold_first_nxt = (r_loads == '0);
      w_hold_last_nxt  = (r_loads == LAST);
      w_loads_nxt      = r_loads + 1'b1;
    end else if (w_need) begin
      w_idx_nxt        = 2'd0;
      w_hold_valid_nxt = 1'b0;
      w_hold_first_nxt = 1'b0;
      w_hold_last_nxt  = 1'b0;
    end else if (w_accept) begin
      w_idx_nxt        = r_idx + 1'b1;
    end
  end

  // Unpacker registers and the registered pixel/sop/eop derived from their next values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word       <= '0;
      r_idx        <= 2'd0;
      r_hold_valid <= 1'b0;
      r_hold_first <= 1'b0;
      r_hold_last  <= 1'b0;
      r_loads      <= '0;
      r_pixel      <= '0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
    end else begin
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_first <= w_hold_first_nxt;
      r_hold_last  <= w_hold_last_nxt;
      r_loads      <= w_loads_nxt;
      r_pixel      <= w_hold_valid_nxt ? pick_pixel(w_word_nxt, w_idx_nxt) : '0;
      r_sop        <= w_hold_valid_nxt && w_hold_first_nxt && (w_idx_nxt == 2'd0);
      r_eop        <= w_hold_valid_nxt && w_hold_last_nxt  && (w_idx_nxt == 2'd3);
    end
  end

  // Frame status: busy while a frame is open, done pulses unless a restart wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_eop_accept && !frame_start;
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: streaming, backpressure, aborts and resets.
module tb_vga_fb_reader;
  import vga_fb_pkg::*;

  localparam int BASE  = 32764;
  localparam int FW    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              pixel_ready = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_write;
  logic [3:0]        avm_byteenable;
  logic [WORD_W-1:0] avm_writedata;
  logic [WORD_W-1:0] avm_readdata = '0;
  logic [PIX_W-1:0]  pixel;
  logic              pixel_valid, pixel_sop, pixel_eop, busy, frame_done;

  int n_vec  = 0;
  int n_miss = 0;
  int issue_cnt [FW];
  int bad_addr    = 0;
  int credit_viol = 0;

  vga_fb_reader #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .pixel          (pixel),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .pixel_sop      (pixel_sop),
    .pixel_eop      (pixel_eop),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // Frame word n holds pixels 4n..4n+3, pixel 4n in the low byte.
  function automatic logic [31:0] word_of(input int n);
    return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
  endfunction

  // Memory model: registered read one cycle after the address edge; logs every read.
  always @(posedge clk) begin
    if (avm_chipselect === 1'b1) begin
      if (int'(avm_address) >= BASE && int'(avm_address) < BASE + FW) begin
        issue_cnt[int'(avm_address) - BASE] += 1;
        avm_readdata <= word_of(int'(avm_address) - BASE);
      end else begin
        bad_addr += 1;
        avm_readdata <= 32'hDEAD_BEEF;
      end
    end
    if (int'(dut.w_fifo_count) + int'(dut.r_inflight) > DEPTH) credit_viol += 1;
  end

  task automatic clear_counts();
    for (int i = 0; i < FW; i++) issue_cnt[i] = 0;
    bad_addr    = 0;
    credit_viol = 0;
  endtask

  // Called at a negedge; frame_start is seen by the next posedge and dropped at the following negedge.
  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (avm_address !== 15'(BASE) || pixel !== 8'h00) begin
      n_miss++;
      $display("FAIL reset_addr_pix: got addr=%0d pix=%0d, want addr=%0d pix=0", avm_address, pixel, BASE);
    end
    n_vec++;
    if ({avm_chipselect, pixel_valid, pixel_sop, pixel_eop, busy, frame_done} !== 6'b0) begin
      n_miss++;
      $display("FAIL reset_flags: got cs,v,sop,eop,busy,done=%b, want 000000",
               {avm_chipselect, pixel_valid, pixel_sop, pixel_eop, busy, frame_done});
    end
    n_vec++;
    if (avm_write !== 1'b0 || avm_byteenable !== 4'hF || avm_writedata !== 32'h0) begin
      n_miss++;
      $display("FAIL tie_offs: got wr=%b be=%h wd=%h, want 0 f 0", avm_write, avm_byteenable, avm_writedata);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (avm_chipselect !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_no_read: got cs=%b busy=%b, want 0 0", avm_chipselect, busy);
    end
  endtask

  task automatic test_stream();
    clear_counts();
    pixel_ready = 1'b1;
    pulse_start();
    n_vec++;
    if (avm_chipselect !== 1'b1 || avm_address !== 15'(BASE) || busy !== 1'b1 || pixel_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL stream_first_read: got cs=%b addr=%0d busy=%b v=%b, want 1 %0d 1 0",
               avm_chipselect, avm_address, busy, pixel_valid, BASE);
    end
    @(negedge clk);
    n_vec++;
    if (pixel_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL stream_latency: got valid=%b one edge after start, want 0", pixel_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel !== 8'(i) || pixel_sop !== 1'(i == 0) ||
          pixel_eop !== 1'(i == 15) || frame_done !== 1'b0) begin
        n_miss++;
        $display("FAIL stream_pix[%0d]: got v=%b pix=%0d sop=%b eop=%b done=%b, want v=1 pix=%0d sop=%b eop=%b done=0",
                 i, pixel_valid, pixel, pixel_sop, pixel_eop, frame_done, i, i == 0, i == 15);
      end
      if (i == 5) begin
        n_vec++;
        if (dut.r_state !== DRAIN) begin
          n_miss++;
          $display("FAIL stream_drain: got state=%0d, want DRAIN", dut.r_state);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL stream_done: got done=%b busy=%b v=%b, want 1 0 0", frame_done, busy, pixel_valid);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0 || dut.r_state !== IDLE) begin
      n_miss++;
      $display("FAIL stream_done_pulse: got done=%b state=%0d, want 0 IDLE", frame_done, dut.r_state);
    end
    for (int i = 0; i < FW; i++) begin
      n_vec++;
      if (issue_cnt[i] !== 1) begin
        n_miss++;
        $display("FAIL stream_addr[%0d]: got %0d reads, want 1", BASE + i, issue_cnt[i]);
      end
    end
    n_vec++;
    if (bad_addr !== 0) begin
      n_miss++;
      $display("FAIL stream_bad_addr: got %0d out-of-frame reads, want 0", bad_addr);
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    logic stall_prev = 1'b0;
    logic [7:0] pix_prev = '0;
    logic sop_prev = 1'b0, eop_prev = 1'b0;
    clear_counts();
    pixel_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 400 && got < 16; c++) begin
      if (stall_prev) begin
        n_vec++;
        if (pixel_valid !== 1'b1 || pixel !== pix_prev || pixel_sop !== sop_prev || pixel_eop !== eop_prev) begin
          n_miss++;
          $display("FAIL bp_stall_hold: got v=%b pix=%0d sop=%b eop=%b, want 1 %0d %b %b",
                   pixel_valid, pixel, pixel_sop, pixel_eop, pix_prev, sop_prev, eop_prev);
        end
      end
      pixel_ready = ($urandom_range(0, 9) < 3);
      if (pixel_valid === 1'b1 && pixel_ready) begin
        n_vec++;
        if (pixel !== 8'(got) || pixel_sop !== 1'(got == 0) || pixel_eop !== 1'(got == 15)) begin
          n_miss++;
          $display("FAIL bp_pix[%0d]: got pix=%0d sop=%b eop=%b, want %0d %b %b",
                   got, pixel, pixel_sop, pixel_eop, got, got == 0, got == 15);
        end
        got++;
      end
      stall_prev = (pixel_valid === 1'b1) && !pixel_ready;
      pix_prev   = pixel;
      sop_prev   = pixel_sop;
      eop_prev   = pixel_eop;
      @(negedge clk);
    end
    pixel_ready = 1'b0;
    n_vec++;
    if (got !== 16 || frame_done !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_done: got %0d pixels done=%b busy=%b, want 16 1 0", got, frame_done, busy);
    end
    n_vec++;
    if (credit_viol !== 0) begin
      n_miss++;
      $display("FAIL bp_credit: got %0d cycles with fifo+inflight>%0d, want 0", credit_viol, DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    pixel_ready = 1'b1;
    pulse_start();
    // Restart one edge after the first read issued: word 0 returns, word 1 is in flight.
    @(negedge clk);
    pulse_start();
    n_vec++;
    if (pixel_valid !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL abort1_flush: got v=%b busy=%b, want 0 1", pixel_valid, busy);
    end
    @(negedge clk);
    n_vec++;
    if (pixel_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL abort1_inflight_drop: got v=%b pix=%0d, want v=0", pixel_valid, pixel);
    end
    @(negedge clk);
    for (int i = 0; i <= 6; i++) begin
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel !== 8'(i) || pixel_sop !== 1'(i == 0) || frame_done !== 1'b0) begin
        n_miss++;
        $display("FAIL abort1_pix[%0d]: got v=%b pix=%0d sop=%b done=%b, want 1 %0d %b 0",
                 i, pixel_valid, pixel, pixel_sop, frame_done, i, i == 0);
      end
      if (i == 6) frame_start = 1'b1;
      @(negedge clk);
    end
    frame_start = 1'b0;
    n_vec++;
    if (pixel_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_miss++;
      $display("FAIL abort2_flush: got v=%b pix=%0d done=%b, want v=0 done=0", pixel_valid, pixel, frame_done);
    end
    @(negedge clk);
    n_vec++;
    if (pixel_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_miss++;
      $display("FAIL abort2_gap: got v=%b pix=%0d done=%b, want v=0 done=0", pixel_valid, pixel, frame_done);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel !== 8'(i) || pixel_sop !== 1'(i == 0) ||
          pixel_eop !== 1'(i == 15) || frame_done !== 1'b0) begin
        n_miss++;
        $display("FAIL abort2_pix[%0d]: got v=%b pix=%0d sop=%b eop=%b done=%b, want 1 %0d %b %b 0",
                 i, pixel_valid, pixel, pixel_sop, pixel_eop, frame_done, i, i == 0, i == 15);
      end
      @(negedge clk);
    end
    n_vec++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL abort2_done: got done=%b busy=%b, want 1 0", frame_done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    pixel_ready = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || pixel_valid !== 1'b1 || pixel !== 8'h00) begin
      n_miss++;
      $display("FAIL rst_pre: got busy=%b v=%b pix=%0d, want 1 1 0", busy, pixel_valid, pixel);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (avm_address !== 15'(BASE) || pixel !== 8'h00 ||
        {avm_chipselect, pixel_valid, pixel_sop, pixel_eop, busy, frame_done} !== 6'b0) begin
      n_miss++;
      $display("FAIL rst_async: got addr=%0d pix=%0d cs,v,sop,eop,busy,done=%b, want %0d 0 000000",
               avm_address, pixel, {avm_chipselect, pixel_valid, pixel_sop, pixel_eop, busy, frame_done}, BASE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_counts();
    repeat (8) @(negedge clk);
    n_vec++;
    if (issue_cnt[0] + issue_cnt[1] + issue_cnt[2] + issue_cnt[3] + bad_addr !== 0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_no_reads: got %0d reads busy=%b, want 0 0",
               issue_cnt[0] + issue_cnt[1] + issue_cnt[2] + issue_cnt[3] + bad_addr, busy);
    end
  endtask

  task automatic test_eop_restart();
    int seen_done = 0;
    pixel_ready = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel !== 8'(i) || pixel_eop !== 1'(i == 15)) begin
        n_miss++;
        $display("FAIL eoprs_pix[%0d]: got v=%b pix=%0d eop=%b, want 1 %0d %b",
                 i, pixel_valid, pixel, pixel_eop, i, i == 15);
      end
      if (i == 15) frame_start = 1'b1;
      @(negedge clk);
    end
    frame_start = 1'b0;
    n_vec++;
    if (frame_done !== 1'b0 || busy !== 1'b1 || pixel_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL eoprs_no_done: got done=%b busy=%b v=%b, want 0 1 0", frame_done, busy, pixel_valid);
    end
    @(negedge clk);
    if (frame_done === 1'b1) seen_done++;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (pixel_valid !== 1'b1 || pixel !== 8'(i) || pixel_sop !== 1'(i == 0) || pixel_eop !== 1'(i == 15)) begin
        n_miss++;
        $display("FAIL eoprs_new[%0d]: got v=%b pix=%0d sop=%b eop=%b, want 1 %0d %b %b",
                 i, pixel_valid, pixel, pixel_sop, pixel_eop, i, i == 0, i == 15);
      end
      if (frame_done === 1'b1) seen_done++;
      @(negedge clk);
    end
    n_vec++;
    if (seen_done !== 0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL eoprs_done: got early_done=%0d done=%b busy=%b, want 0 1 0", seen_done, frame_done, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    test_eop_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
